piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, number of data bits per word (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: load_valid  input  1  upstream asserts a word is present on load_data.
REQ-005 SHALL have port: load_data  input  WIDTH  parallel word to serialize.
REQ-006 SHALL have port: load_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have port: Data_out  output  1  serial bit stream, MSB first, drives the downstream detector's Data_in.
REQ-008 SHALL have port: bit_valid  output  1  Data_out carries a frame bit this cycle.
REQ-009 SHALL have port: frame_done  output  1  one-cycle pulse marking the final bit of a frame.

Function
REQ-010 SHALL accept a word at a rising edge where load_valid=1 and load_ready=1, capturing load_data at that edge.
REQ-011 SHALL ignore load_valid and load_data whenever load_ready=0; load_data need not be stable outside the accept edge.
REQ-012 SHALL use the states IDLE, SHIFT and PARITY (PARITY reachable only per REQ-024).
REQ-013 SHALL transition IDLE->SHIFT on accept; SHIFT->SHIFT until WIDTH bits are emitted; then SHIFT->PARITY (parity built in), else SHIFT->IDLE, or SHIFT->SHIFT on a new accept.
REQ-014 SHALL, for a word accepted at edge E, present bit WIDTH-1 on Data_out in the cycle after E and bits WIDTH-2..0 in the following cycles, one bit per clock.
REQ-015 SHALL hold bit_valid=1 in every cycle that Data_out carries a frame bit, including the parity bit, and 0 otherwise.
REQ-016 SHALL drive Data_out=0 whenever bit_valid=0.
REQ-017 SHALL assert frame_done=1 only in the cycle carrying the last bit of the frame (bit 0, or the parity bit when parity is built in).
REQ-018 SHALL drive load_ready=1 in IDLE and during the frame_done cycle, and 0 otherwise; load_ready is combinational from state and bit counter only, with no path from load_valid.
REQ-019 SHALL, on accept during the frame_done cycle, emit the new word's MSB in the very next cycle with bit_valid=1, leaving no gap between frames.
REQ-020 SHALL size the bit counter as clog2(WIDTH) bits, with terminal count WIDTH-1 and no wrap inside a frame.
REQ-021 SHALL register Data_out, bit_valid and frame_done with no combinational path from any input.

Reset
REQ-022 SHALL, with rst=1 at a rising edge, set state=IDLE, Data_out=0, bit_valid=0, frame_done=0, and clear the shift register and bit counter.
REQ-023 SHALL hold load_ready=0 while rst=1 and ignore load_valid; reset mid-frame abandons the frame, emits no further bits, and load_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-024 SHALL build in a parity bit when macro PISO_PARITY_EN is defined: state PARITY appends one extra bit after bit 0, equal to the XOR of all WIDTH captured bits (even parity), giving WIDTH+1 bits per frame.
REQ-025 SHALL omit PARITY state and logic when PISO_PARITY_EN is undefined, giving exactly WIDTH bits per frame.

Verification
REQ-026 SHALL pass: WIDTH=4, accept 4'b1011 at edge 0 -> Data_out 1,0,1,1 in cycles 1-4, bit_valid=1 in cycles 1-4, frame_done=1 in cycle 4 only, then IDLE with load_ready=1.
REQ-027 SHALL pass: WIDTH=4, words 4'b1011 then 4'b0110 back-to-back with load_valid held high -> 8 contiguous valid bits 1,0,1,1,0,1,1,0 and two frame_done pulses in cycles 4 and 8.
REQ-028 SHALL pass: WIDTH=8, load_valid=1 with 8'hFF in cycles 2-5 while busy with 8'h00 -> 8'hFF ignored, serial stream 8 zeros, load_ready=0 in cycles 1-7.
REQ-029 SHALL pass: WIDTH=8, rst=1 in cycle 3 of frame 8'hC3 -> Data_out=0, bit_valid=0 from the next cycle, no frame_done, and 8'h81 accepted in the first cycle after rst deasserts serializes fully.
REQ-030 SHALL pass: PISO_PARITY_EN defined, WIDTH=8, words 8'hA5 then 8'h01 -> parity bits 0 then 1 in cycles 9 and 18, frame_done in cycles 9 and 18.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in serial-out word serializer, MSB first, with back-to-back frame support.
// Define PISO_PARITY_EN to append an even-parity bit after bit 0 of every frame.
module piso_serializer #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   output logic             load_ready,
   output logic             Data_out,
   output logic             bit_valid,
   output logic             frame_done
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef PISO_PARITY_EN
   localparam logic [1:0] ST_PARITY = 2'd2;
`endif

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             dout_q,  dout_d;
   logic             bv_q,    bv_d;
   logic             fd_q,    fd_d;
`ifdef PISO_PARITY_EN
   logic             parity_q, parity_d;
`endif

   logic last_c;
   logic accept_c;

   // cnt_q indexes the bit currently on Data_out; WIDTH-1 means bit 0 is showing
   assign last_c = (state_q == ST_SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));

`ifdef PISO_PARITY_EN
   assign load_ready = !rst && ((state_q == ST_IDLE) || (state_q == ST_PARITY));
`else
   assign load_ready = !rst && ((state_q == ST_IDLE) || last_c);
`endif

   assign accept_c = load_valid && load_ready;

   // Next-state and next-output logic
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      cnt_d    = cnt_q;
      dout_d   = 1'b0;
      bv_d     = 1'b0;
      fd_d     = 1'b0;
`ifdef PISO_PARITY_EN
      parity_d = parity_q;
`endif

      case (state_q)
         ST_IDLE: state_d = ST_IDLE;
         ST_SHIFT: begin
            if (!last_c) begin
               dout_d  = shreg_q[WIDTH-1];
               shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
               cnt_d   = cnt_q + CNT_W'(1);
               bv_d    = 1'b1;
`ifndef PISO_PARITY_EN
               fd_d    = (cnt_q == CNT_W'(WIDTH - 2));
`endif
            end else begin
`ifdef PISO_PARITY_EN
               state_d = ST_PARITY;
               dout_d  = parity_q;
               bv_d    = 1'b1;
               fd_d    = 1'b1;
`else
               state_d = ST_IDLE;
`endif
            end
         end
`ifdef PISO_PARITY_EN
         ST_PARITY: state_d = ST_IDLE;
`endif
         default: state_d = ST_IDLE;
      endcase

      // Accept is only possible when the current frame is finished, so it overrides
      if (accept_c) begin
         state_d  = ST_SHIFT;
         dout_d   = load_data[WIDTH-1];
         bv_d     = 1'b1;
         fd_d     = 1'b0;
         shreg_d  = {load_data[WIDTH-2:0], 1'b0};
         cnt_d    = '0;
`ifdef PISO_PARITY_EN
         parity_d = ^load_data;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         shreg_q  <= '0;
         cnt_q    <= '0;
         dout_q   <= 1'b0;
         bv_q     <= 1'b0;
         fd_q     <= 1'b0;
`ifdef PISO_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         bv_q     <= bv_d;
         fd_q     <= fd_d;
`ifdef PISO_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign Data_out   = dout_q;
   assign bit_valid  = bv_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: a WIDTH=4 vector table plus WIDTH=8 hand sequences.
// Expectations follow PISO_PARITY_EN when it is defined.
module tb_piso_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst4, lv4, lr4, do4, bv4, fd4;
   logic [3:0] ld4;
   logic       rst8, lv8, lr8, do8, bv8, fd8;
   logic [7:0] ld8;

   piso_serializer #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst4), .load_valid(lv4), .load_data(ld4),
      .load_ready(lr4), .Data_out(do4), .bit_valid(bv4), .frame_done(fd4));

   piso_serializer #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst8), .load_valid(lv8), .load_data(ld8),
      .load_ready(lr8), .Data_out(do8), .bit_valid(bv8), .frame_done(fd8));

`ifdef PISO_PARITY_EN
   localparam int FL8 = 9;
`else
   localparam int FL8 = 8;
`endif

   typedef struct {
      logic       rst;
      logic       lv;
      logic [3:0] d;
      logic       e_do;
      logic       e_bv;
      logic       e_fd;
      logic       e_lr;
   } vec_t;

   vec_t tbl[$];
   int   checks = 0;
   int   errors = 0;

   function automatic vec_t mk(input logic r, input logic v, input logic [3:0] d,
                               input logic o, input logic b, input logic f, input logic l);
      vec_t t;
      t.rst = r; t.lv = v; t.d = d; t.e_do = o; t.e_bv = b; t.e_fd = f; t.e_lr = l;
      return t;
   endfunction

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic e_do, input logic e_bv,
                       input logic e_fd, input logic e_lr);
      chk({tag, " Data_out"},   do8, e_do);
      chk({tag, " bit_valid"},  bv8, e_bv);
      chk({tag, " frame_done"}, fd8, e_fd);
      chk({tag, " load_ready"}, lr8, e_lr);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected frame bit c (1-based): data MSB first, then even parity
   function automatic logic frame_bit(input logic [7:0] w, input int c);
      if (c <= 8) return w[8-c];
      return ^w;
   endfunction

   initial begin
      rst4 = 1'b1; lv4 = 1'b0; ld4 = '0;
      rst8 = 1'b1; lv8 = 1'b0; ld8 = '0;

`ifdef PISO_PARITY_EN
      tbl.push_back(mk(1,0,4'h0, 0,0,0,0));
      tbl.push_back(mk(0,0,4'h0, 0,0,0,1));
      tbl.push_back(mk(0,1,4'hB, 1,1,0,0));
      tbl.push_back(mk(0,1,4'hF, 0,1,0,0));
      tbl.push_back(mk(0,0,4'h0, 1,1,0,0));
      tbl.push_back(mk(0,0,4'h0, 1,1,0,0));
      tbl.push_back(mk(0,0,4'h0, 1,1,1,1));
      tbl.push_back(mk(0,0,4'h0, 0,0,0,1));
      tbl.push_back(mk(0,1,4'hB, 1,1,0,0));
      tbl.push_back(mk(0,1,4'h6, 0,1,0,0));
      tbl.push_back(mk(0,1,4'h6, 1,1,0,0));
      tbl.push_back(mk(0,1,4'h6, 1,1,0,0));
      tbl.push_back(mk(0,1,4'h6, 1,1,1,1));
      tbl.push_back(mk(0,1,4'h6, 0,1,0,0));
      tbl.push_back(mk(0,0,4'h0, 1,1,0,0));
      tbl.push_back(mk(0,0,4'h0, 1,1,0,0));
      tbl.push_back(mk(0,0,4'h0, 0,1,0,0));
      tbl.push_back(mk(0,0,4'h0, 0,1,1,1));
      tbl.push_back(mk(0,0,4'h0, 0,0,0,1));
`else
      tbl.push_back(mk(1,0,4'h0, 0,0,0,0));
      tbl.push_back(mk(0,0,4'h0, 0,0,0,1));
      tbl.push_back(mk(0,1,4'hB, 1,1,0,0));
      tbl.push_back(mk(0,1,4'hF, 0,1,0,0));
      tbl.push_back(mk(0,0,4'h0, 1,1,0,0));
      tbl.push_back(mk(0,0,4'h0, 1,1,1,1));
      tbl.push_back(mk(0,0,4'h0, 0,0,0,1));
      tbl.push_back(mk(0,1,4'hB, 1,1,0,0));
      tbl.push_back(mk(0,1,4'h6, 0,1,0,0));
      tbl.push_back(mk(0,1,4'h6, 1,1,0,0));
      tbl.push_back(mk(0,1,4'h6, 1,1,1,1));
      tbl.push_back(mk(0,1,4'h6, 0,1,0,0));
      tbl.push_back(mk(0,0,4'h0, 1,1,0,0));
      tbl.push_back(mk(0,0,4'h0, 1,1,0,0));
      tbl.push_back(mk(0,0,4'h0, 0,1,1,1));
      tbl.push_back(mk(0,0,4'h0, 0,0,0,1));
`endif

      // WIDTH=4 table: single frame, ignored load while busy, back-to-back frames
      foreach (tbl[i]) begin
         rst4 = tbl[i].rst; lv4 = tbl[i].lv; ld4 = tbl[i].d;
         step();
         chk($sformatf("w4 v%0d Data_out", i),   do4, tbl[i].e_do);
         chk($sformatf("w4 v%0d bit_valid", i),  bv4, tbl[i].e_bv);
         chk($sformatf("w4 v%0d frame_done", i), fd4, tbl[i].e_fd);
         chk($sformatf("w4 v%0d load_ready", i), lr4, tbl[i].e_lr);
      end

      // WIDTH=8: 8'hFF offered while busy serializing 8'h00 must be ignored
      rst8 = 1'b0; lv8 = 1'b0;
      step();
      chk8("w8 idle", 1'b0, 1'b0, 1'b0, 1'b1);
      lv8 = 1'b1; ld8 = 8'h00;
      step();
      for (int c = 1; c <= FL8; c++) begin
         chk8($sformatf("busy c%0d", c), 1'b0, 1'b1, c == FL8, c == FL8);
         lv8 = (c >= 2 && c <= 5);
         ld8 = 8'hFF;
         step();
      end
      chk8("busy end", 1'b0, 1'b0, 1'b0, 1'b1);

      // WIDTH=8: reset mid-frame of 8'hC3, then 8'h81 right after release
      lv8 = 1'b1; ld8 = 8'hC3;
      step();
      chk8("rst c1", 1'b1, 1'b1, 1'b0, 1'b0);
      lv8 = 1'b0;
      step();
      chk8("rst c2", 1'b1, 1'b1, 1'b0, 1'b0);
      step();
      chk8("rst c3", 1'b0, 1'b1, 1'b0, 1'b0);
      rst8 = 1'b1; lv8 = 1'b1; ld8 = 8'hFF;
      step();
      chk8("rst c4", 1'b0, 1'b0, 1'b0, 1'b0);
      rst8 = 1'b0; lv8 = 1'b1; ld8 = 8'h81;
      #1;
      chk("rst release load_ready", lr8, 1'b1);
      step();
      for (int c = 1; c <= FL8; c++) begin
         chk8($sformatf("post-rst c%0d", c), frame_bit(8'h81, c), 1'b1, c == FL8, c == FL8);
         lv8 = 1'b0;
         step();
      end
      chk8("post-rst end", 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef PISO_PARITY_EN
      // WIDTH=8 with parity: 8'hA5 then 8'h01 back-to-back
      lv8 = 1'b1; ld8 = 8'hA5;
      step();
      for (int c = 1; c <= 18; c++) begin
         logic [7:0] w;
         int k;
         w = (c <= 9) ? 8'hA5 : 8'h01;
         k = (c <= 9) ? c : c - 9;
         chk8($sformatf("par c%0d", c), frame_bit(w, k), 1'b1, k == 9, k == 9);
         if (c == 1) lv8 = 1'b0;
         if (c == 9) begin lv8 = 1'b1; ld8 = 8'h01; end
         if (c == 10) lv8 = 1'b0;
         step();
      end
      chk8("par end", 1'b0, 1'b0, 1'b0, 1'b1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
